// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch queue and its neighbours.
//   INST_W, PC_W : instruction and PC widths used across the fetch/decode path
//   FQ_DEPTH     : default fetch queue depth (entries)
//   LANES        : instructions per fetch group / decode group
//   fq_entry_t   : one queue entry {inst, pc}
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INST_W   = 16;
    localparam int PC_W     = 16;
    localparam int FQ_DEPTH = 16;
    localparam int LANES    = 4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// -----------------------------------------------------------------------------
// fetch_queue_storage
// DEPTH-entry register array with LANES write ports and LANES read ports.
// Holds data only; all pointer and occupancy control lives in fetch_queue.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (array cleared to zero)
//   we_i      : per-lane write enable
//   waddr_i   : per-lane write address
//   wdata_i   : per-lane write data
//   raddr_i   : per-lane read address
//   rdata_o   : per-lane read data (combinational from the array)
// -----------------------------------------------------------------------------
module fetch_queue_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] we_i,
    input  logic [PTR_W-1:0] waddr_i [LANES],
    input  fq_entry_t        wdata_i [LANES],
    input  logic [PTR_W-1:0] raddr_i [LANES],
    output fq_entry_t        rdata_o [LANES]
);

    fq_entry_t mem_q [DEPTH];

    // Write lanes always target distinct addresses, so lane order is irrelevant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (we_i[k]) begin
                    mem_q[waddr_i[k]] <= wdata_i[k];
                end
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_rd
        assign rdata_o[j] = mem_q[raddr_i[j]];
    end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch queue between the four-wide fetch stage and decode.
// Accepts up to four instructions per cycle (all-or-nothing), presents the
// four oldest to decode, and discards everything on flush.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward an incoming group
// straight to the outputs in the same cycle when the queue is empty.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : clear head/tail/count (takes priority over all)
//   in_valid, in_cnt    : fetch group valid and size (1..4)
//   in_pc               : PC of in_inst0
//   in_inst0..3         : fetched instructions, in_inst0 oldest
//   in_ready            : at least four free entries
//   out_cnt             : number of valid output slots
//   out_inst0..3        : oldest entries, out_inst0 oldest
//   out_pc0..3          : PC of each output slot
//   deq_cnt             : entries consumed by decode (clamped to out_cnt)
//   count               : current occupancy
// Widths INST_W / PC_W come from fetch_pkg.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [2:0]             in_cnt,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [INST_W-1:0]      in_inst0,
    input  logic [INST_W-1:0]      in_inst1,
    input  logic [INST_W-1:0]      in_inst2,
    input  logic [INST_W-1:0]      in_inst3,
    output logic                   in_ready,
    output logic [2:0]             out_cnt,
    output logic [INST_W-1:0]      out_inst0,
    output logic [INST_W-1:0]      out_inst1,
    output logic [INST_W-1:0]      out_inst2,
    output logic [INST_W-1:0]      out_inst3,
    output logic [PC_W-1:0]        out_pc0,
    output logic [PC_W-1:0]        out_pc1,
    output logic [PC_W-1:0]        out_pc2,
    output logic [PC_W-1:0]        out_pc3,
    input  logic [2:0]             deq_cnt,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [INST_W-1:0] in_inst [LANES];
    logic [2:0]        occ_cnt;
    logic              cnt_ok;
    logic              enq;
    logic              bypass;
    logic [2:0]        deq_eff;
    logic [2:0]        skip;
    logic [2:0]        wr_n;
    logic [2:0]        head_adv;

    logic [LANES-1:0]  we;
    logic [PTR_W-1:0]  waddr [LANES];
    fq_entry_t         wdata [LANES];
    logic [PTR_W-1:0]  raddr [LANES];
    fq_entry_t         rdata [LANES];

    assign in_inst[0] = in_inst0;
    assign in_inst[1] = in_inst1;
    assign in_inst[2] = in_inst2;
    assign in_inst[3] = in_inst3;

    // Handshake derived from registered occupancy only.
    assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(LANES);
    assign occ_cnt  = (count_q >= CNT_W'(LANES)) ? 3'd4 : count_q[2:0];
    assign cnt_ok   = (in_cnt != 3'd0) && (in_cnt <= 3'd4);
    assign enq      = in_valid && in_ready && !flush && cnt_ok;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = enq && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign out_cnt = bypass ? in_cnt : occ_cnt;
    assign deq_eff = (deq_cnt < out_cnt) ? deq_cnt : out_cnt;

    // On a bypassed group, decode consumes the oldest deq_eff lanes directly
    // from the inputs; only the younger remainder is stored and head stays.
    assign skip     = bypass ? deq_eff : 3'd0;
    assign wr_n     = enq ? (in_cnt - skip) : 3'd0;
    assign head_adv = bypass ? 3'd0 : deq_eff;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(head_adv);
            tail_d  = tail_q + PTR_W'(wr_n);
            count_d = count_q + CNT_W'(wr_n) - CNT_W'(head_adv);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CNT_W'(DEPTH));
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        // Lane k lands at tail + (k - skip); lanes below skip are not written.
        assign we[k]         = enq && (3'(k) >= skip) && (3'(k) < in_cnt);
        assign waddr[k]      = tail_q + PTR_W'(3'(k) - skip);
        assign wdata[k].inst = in_inst[k];
        assign wdata[k].pc   = in_pc + PC_W'(k);
        assign raddr[k]      = head_q + PTR_W'(k);
    end

    fetch_queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign out_inst0 = bypass ? in_inst[0]          : rdata[0].inst;
    assign out_inst1 = bypass ? in_inst[1]          : rdata[1].inst;
    assign out_inst2 = bypass ? in_inst[2]          : rdata[2].inst;
    assign out_inst3 = bypass ? in_inst[3]          : rdata[3].inst;
    assign out_pc0   = bypass ? in_pc               : rdata[0].pc;
    assign out_pc1   = bypass ? in_pc + PC_W'(1)    : rdata[1].pc;
    assign out_pc2   = bypass ? in_pc + PC_W'(2)    : rdata[2].pc;
    assign out_pc3   = bypass ? in_pc + PC_W'(3)    : rdata[3].pc;

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_cnt = 3'd0;
    logic [15:0] in_pc = 16'h0;
    logic [15:0] in_inst0 = 16'h0, in_inst1 = 16'h0, in_inst2 = 16'h0, in_inst3 = 16'h0;
    logic        in_ready;
    logic [2:0]  out_cnt;
    logic [15:0] out_inst0, out_inst1, out_inst2, out_inst3;
    logic [15:0] out_pc0, out_pc1, out_pc2, out_pc3;
    logic [2:0]  deq_cnt = 3'd0;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_cnt    (in_cnt),
        .in_pc     (in_pc),
        .in_inst0  (in_inst0),
        .in_inst1  (in_inst1),
        .in_inst2  (in_inst2),
        .in_inst3  (in_inst3),
        .in_ready  (in_ready),
        .out_cnt   (out_cnt),
        .out_inst0 (out_inst0),
        .out_inst1 (out_inst1),
        .out_inst2 (out_inst2),
        .out_inst3 (out_inst3),
        .out_pc0   (out_pc0),
        .out_pc1   (out_pc1),
        .out_pc2   (out_pc2),
        .out_pc3   (out_pc3),
        .deq_cnt   (deq_cnt),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] n, input logic [15:0] pc,
                         input logic [15:0] i0, input logic [15:0] i1,
                         input logic [15:0] i2, input logic [15:0] i3,
                         input logic [2:0] dq);
        in_valid = v;
        in_cnt   = n;
        in_pc    = pc;
        in_inst0 = i0;
        in_inst1 = i1;
        in_inst2 = i2;
        in_inst3 = i3;
        deq_cnt  = dq;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_cnt   = 3'd0;
        deq_cnt  = 3'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_inst0", 32'(out_inst0), 32'h0);
        chk("rst_out_pc0", 32'(out_pc0), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic flow
        drive(1, 3'd4, 16'h0100, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 3'd0);
        cyc(); idle();
        chk("basic_out_cnt", 32'(out_cnt), 32'd4);
        chk("basic_pc0", 32'(out_pc0), 32'h0100);
        chk("basic_pc1", 32'(out_pc1), 32'h0101);
        chk("basic_pc2", 32'(out_pc2), 32'h0102);
        chk("basic_pc3", 32'(out_pc3), 32'h0103);
        chk("basic_inst0", 32'(out_inst0), 32'hA000);
        chk("basic_inst3", 32'(out_inst3), 32'hA003);
        chk("basic_count", 32'(count), 32'd4);

        // Fill to DEPTH
        drive(1, 3'd4, 16'h0200, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 3'd0);
        cyc();
        drive(1, 3'd4, 16'h0300, 16'hB100, 16'hB101, 16'hB102, 16'hB103, 3'd0);
        cyc();
        chk("fill12_in_ready", 32'(in_ready), 32'd1);
        drive(1, 3'd4, 16'h0400, 16'hB200, 16'hB201, 16'hB202, 16'hB203, 3'd0);
        cyc();
        chk("fill16_count", 32'(count), 32'd16);
        chk("fill16_in_ready", 32'(in_ready), 32'd0);
        chk("fill16_pc0", 32'(out_pc0), 32'h0100);
        drive(1, 3'd4, 16'h0500, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 3'd0);
        cyc();
        chk("held_count", 32'(count), 32'd16);
        deq_cnt = 3'd4;
        cyc();
        chk("full_deq_count", 32'(count), 32'd12);
        chk("full_deq_pc0", 32'(out_pc0), 32'h0200);
        deq_cnt = 3'd0;
        cyc(); idle();
        chk("held_accept_count", 32'(count), 32'd16);

        // Drain and check order
        deq_cnt = 3'd4;
        cyc();
        chk("drain1_pc0", 32'(out_pc0), 32'h0300);
        cyc();
        chk("drain2_pc0", 32'(out_pc0), 32'h0400);
        cyc();
        chk("drain3_pc0", 32'(out_pc0), 32'h0500);
        chk("drain3_inst3", 32'(out_inst3), 32'hC003);
        chk("drain3_count", 32'(count), 32'd4);
        cyc();
        chk("drain4_count", 32'(count), 32'd0);
        chk("drain4_out_cnt", 32'(out_cnt), 32'd0);
        cyc(); idle();
        chk("empty_deq_count", 32'(count), 32'd0);
        chk("empty_deq_out_cnt", 32'(out_cnt), 32'd0);

        // Wrap with PC overflow: bring tail to 14 (head=tail=4 here)
        drive(1, 3'd4, 16'h1000, 16'hE000, 16'hE001, 16'hE002, 16'hE003, 3'd0);
        cyc();
        drive(1, 3'd4, 16'h1004, 16'hE004, 16'hE005, 16'hE006, 16'hE007, 3'd4);
        cyc();
        drive(1, 3'd2, 16'h1008, 16'hE008, 16'hE009, 16'h0000, 16'h0000, 3'd4);
        cyc();
        chk("pre_wrap_count", 32'(count), 32'd2);
        chk("pre_wrap_pc0", 32'(out_pc0), 32'h1008);
        drive(1, 3'd3, 16'hFFFE, 16'hD000, 16'hD001, 16'hD002, 16'h0000, 3'd0);
        cyc(); idle();
        chk("wrap_count", 32'(count), 32'd5);
        chk("wrap_pc2", 32'(out_pc2), 32'hFFFE);
        chk("wrap_pc3", 32'(out_pc3), 32'hFFFF);
        chk("wrap_inst2", 32'(out_inst2), 32'hD000);
        deq_cnt = 3'd2;
        cyc(); idle();
        chk("wrap_out_cnt", 32'(out_cnt), 32'd3);
        chk("wrap_h_pc0", 32'(out_pc0), 32'hFFFE);
        chk("wrap_h_pc1", 32'(out_pc1), 32'hFFFF);
        chk("wrap_h_pc2", 32'(out_pc2), 32'h0000);
        chk("wrap_h_inst2", 32'(out_inst2), 32'hD002);

        // Simultaneous enqueue/dequeue
        drive(1, 3'd3, 16'h2000, 16'hF000, 16'hF001, 16'hF002, 16'h0000, 3'd0);
        cyc();
        chk("sim_pre_count", 32'(count), 32'd6);
        drive(1, 3'd2, 16'h3000, 16'h9000, 16'h9001, 16'h0000, 16'h0000, 3'd4);
        cyc(); idle();
        chk("sim_count", 32'(count), 32'd4);
        chk("sim_inst0", 32'(out_inst0), 32'hF001);
        chk("sim_pc0", 32'(out_pc0), 32'h2001);
        chk("sim_pc2", 32'(out_pc2), 32'h3000);
        chk("sim_inst3", 32'(out_inst3), 32'h9001);

        // Flush priority
        flush = 1'b1;
        drive(1, 3'd4, 16'h6000, 16'h6660, 16'h6661, 16'h6662, 16'h6663, 3'd2);
        cyc(); idle();
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_cnt", 32'(out_cnt), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_stale_inst0", 32'(out_inst0), 32'hD002);
        drive(1, 3'd1, 16'h4000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 3'd0);
        cyc(); idle();
        chk("post_flush_out_cnt", 32'(out_cnt), 32'd1);
        chk("post_flush_inst0", 32'(out_inst0), 32'h1234);
        chk("post_flush_pc0", 32'(out_pc0), 32'h4000);

        // Illegal in_cnt = 0 is ignored
        drive(1, 3'd0, 16'h7777, 16'hBAD0, 16'hBAD1, 16'hBAD2, 16'hBAD3, 3'd0);
        cyc(); idle();
        chk("cnt0_count", 32'(count), 32'd1);
        chk("cnt0_inst0", 32'(out_inst0), 32'h1234);

        // Over-dequeue clamps
        deq_cnt = 3'd4;
        cyc(); idle();
        chk("clamp_count", 32'(count), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Same-cycle forwarding on an empty queue
        drive(1, 3'd3, 16'h5000, 16'h7000, 16'h7001, 16'h7002, 16'h0000, 3'd1);
        #1;
        chk("byp_out_cnt", 32'(out_cnt), 32'd3);
        chk("byp_pc2", 32'(out_pc2), 32'h5002);
        chk("byp_inst0", 32'(out_inst0), 32'h7000);
        cyc(); idle();
        chk("byp_count", 32'(count), 32'd2);
        chk("byp_next_inst0", 32'(out_inst0), 32'h7001);
        chk("byp_next_pc0", 32'(out_pc0), 32'h5001);
        deq_cnt = 3'd4;
        cyc(); idle();
`endif

        // Asynchronous reset mid-run with count = 9
        drive(1, 3'd4, 16'h8000, 16'h8800, 16'h8801, 16'h8802, 16'h8803, 3'd0);
        cyc();
        drive(1, 3'd4, 16'h8004, 16'h8804, 16'h8805, 16'h8806, 16'h8807, 3'd0);
        cyc();
        drive(1, 3'd1, 16'h8008, 16'h8808, 16'h0000, 16'h0000, 16'h0000, 3'd0);
        cyc(); idle();
        chk("pre_rst_count", 32'(count), 32'd9);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_inst0", 32'(out_inst0), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 3'd2, 16'h9000, 16'h4321, 16'h4322, 16'h0000, 16'h0000, 3'd0);
        cyc(); idle();
        chk("post_rst_count", 32'(count), 32'd2);
        chk("post_rst_inst0", 32'(out_inst0), 32'h4321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue, placed directly downstream of the four-wide instruction memory fetch stage and upstream of decode. Each cycle it accepts up to four 16-bit instructions together with the PC of the first instruction. It presents up to four of the oldest instructions, with their PCs, to decode. It decouples fetch from decode stalls, and discards its contents on a pipeline flush.

## Interface
- DEPTH, 16, number of instruction entries; power of two, minimum 8
- INST_W, 16, instruction width
- PC_W, 16, PC width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all queued entries (branch redirect or exception)
- in_valid  in  1  fetch presents an instruction group
- in_cnt  in  3  number of valid instructions in the group, 1..4; in_inst0 is always the oldest
- in_pc  in  PC_W  PC of in_inst0
- in_inst0..in_inst3  in  INST_W each  fetched instructions
- in_ready  out  1  asserted when free entries >= 4
- out_cnt  out  3  number of valid output slots: min(count, 4), or the bypass value (see Configuration)
- out_inst0..out_inst3  out  INST_W each  oldest four entries; out_inst0 is the oldest
- out_pc0..out_pc3  out  PC_W each  PC of each output slot
- deq_cnt  in  3  number of entries decode consumes this cycle, 0..4
- count  out  log2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry holds {inst, pc}. The buffer has a head pointer (oldest entry), a tail pointer (next free entry) and an occupancy count.
- Enqueue fires when in_valid && in_ready && !flush.
  - Instruction k (k < in_cnt) is written to entry tail+k, with pc = in_pc + k (modulo 2^PC_W).
  - tail advances by in_cnt; pointers wrap modulo DEPTH.
- Enqueue is all-or-nothing. When in_ready=0, the group is not taken, and fetch must hold it until in_ready=1.
- in_cnt = 0 with in_valid = 1 is illegal. The queue treats it as no enqueue.
- Dequeue: deq_eff = min(deq_cnt, out_cnt). head advances by deq_eff. deq_cnt values above out_cnt are clamped, never underflow.
- Simultaneous enqueue and dequeue: count_next = count + in_cnt − deq_eff.
- in_ready depends only on registered count, not on the same-cycle dequeue.
- Output slot j (j < out_cnt) shows entry head+j. Slots with j >= out_cnt show stale data, and decode must ignore them.
- Flush takes priority over everything in the cycle it is asserted.
  - head, tail and count are cleared to 0. Enqueue and dequeue in that cycle are ignored.
  - Entry contents are not cleared.
- count can never exceed DEPTH. The in_ready rule guarantees this, and an assertion must check it.

## Timing
- Reset values:
  - count = 0, head = 0, tail = 0, in_ready = 1, out_cnt = 0.
  - All storage entries = 0, so out_inst* = 0 and out_pc* = 0.
- Enqueue-to-visible latency is 1 cycle: a group accepted in cycle N appears on out_* in cycle N+1. With the bypass feature it appears in cycle N (see Configuration).
- Flush latency: out_cnt = 0 and in_ready = 1 in the cycle after flush is asserted.
- in_ready, out_cnt and count are driven from registers only, apart from the bypass path.
- Reset asserted mid-operation clears state immediately, asynchronously. The first enqueue is accepted on the first edge after rst deasserts.
- Full boundary: with count = DEPTH−3, in_ready = 0, even if decode dequeues 4 in the same cycle.
- Empty boundary: with count = 0, out_cnt = 0, and any deq_cnt is ignored.

## Configuration
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count = 0 and enqueue fires, the inputs are forwarded combinationally to the outputs in the same cycle.
  - out_inst* = in_inst*, out_pc* = in_pc + j, out_cnt = in_cnt.
  - Only in_cnt − deq_eff entries are written, namely the unconsumed younger ones.
- Not defined: no combinational input-to-output path. Zero-occupancy latency is 1 cycle.

## Structure
- Shared package fetch_pkg holds:
  - INST_W and PC_W constants.
  - The fq_entry_t typedef {inst, pc}.
  - The default depth constant FQ_DEPTH = 16.
- One sub-module, fetch_queue_storage: DEPTH-entry register array with 4 write ports and 4 read ports, addressed by head+j and tail+k. It contains a reset-to-zero array and no control logic.
- Pointer, count and handshake logic stays in fetch_queue.

## Test plan
- Reset: assert rst mid-run with count = 9 -> immediately count = 0, out_cnt = 0, in_ready = 1, out_inst0 = 0.
- Basic flow: enqueue in_cnt = 4, in_pc = 0x0100, inst 0xA000..0xA003, deq_cnt = 0 -> next cycle out_cnt = 4, out_pc0..3 = 0x0100..0x0103, count = 4.
- Fill: enqueue 4 per cycle with no dequeue, DEPTH = 16 -> in_ready drops when count = 16 (it is already low from count = 13). A 5th group is held and not lost, and is accepted after deq_cnt = 4.
- Wrap and PC overflow: in_pc = 0xFFFE, in_cnt = 3, with tail = 14 -> entries 14, 15, 0 hold pc 0xFFFE, 0xFFFF, 0x0000. Output order is preserved.
- Simultaneous: count = 6, enqueue in_cnt = 2, deq_cnt = 4 -> count = 4 next cycle, and out_inst0 is the old entry at head+4.
- Flush priority: flush = 1 with in_valid = 1, in_cnt = 4 and deq_cnt = 2 -> next cycle count = 0, out_cnt = 0. With FETCH_QUEUE_BYPASS_EN defined and count = 0, enqueue in_cnt = 3, deq_cnt = 1 -> same-cycle out_cnt = 3, then count = 2.
